// File: rtl/cond_eval32_if.sv
// Request/response handshake bundle for the condition-code evaluator.
// The master issues condition-check requests and consumes responses;
// the slave (cond_eval32) accepts requests and presents responses.
interface cond_eval32_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic [3:0]       req_cond;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_taken;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_cond, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_taken, rsp_err, rsp_tag
    );

    modport slave (
        input  req_valid, req_cond, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_taken, rsp_err, rsp_tag
    );
endinterface

// File: rtl/cond_eval32.sv
// Condition-code evaluator and NZCV flag register.
// Latches ALU flags, evaluates 4-bit condition codes against them (with
// same-cycle forwarding of incoming flags), returns the result through a
// single-entry response register and keeps saturating taken/not-taken counts.
module cond_eval32 #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic             c_in,
    input  logic             n_in,
    input  logic             z_in,
    input  logic             v_in,
    input  logic             flag_clr,
    cond_eval32_if.slave     bus,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_not_taken,
    input  logic             cnt_clr
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [3:0]       eff_flags_s;
    logic             rsp_taken_q, rsp_taken_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
    logic [CNT_W-1:0] cnt_nt_q, cnt_nt_d;
    logic             accept_s;
    logic [1:0]       eval_s;

    // Decode a condition code against flags {N,Z,C,V}; returns {err, taken}.
    function automatic logic [1:0] eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic [1:0] res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    res = {1'b0, z};
            4'h1:    res = {1'b0, ~z};
            4'h2:    res = {1'b0, c};
            4'h3:    res = {1'b0, ~c};
            4'h4:    res = {1'b0, n};
            4'h5:    res = {1'b0, ~n};
            4'h6:    res = {1'b0, v};
            4'h7:    res = {1'b0, ~v};
            4'h8:    res = {1'b0, c & ~z};
            4'h9:    res = {1'b0, ~c | z};
            4'hA:    res = {1'b0, ~(n ^ v)};
            4'hB:    res = {1'b0, n ^ v};
            4'hC:    res = {1'b0, ~z & ~(n ^ v)};
            4'hD:    res = {1'b0, z | (n ^ v)};
            4'hE:    res = 2'b01;
            default: res = 2'b10;
        endcase
        return res;
    endfunction

    // Ready whenever the response slot is free or is being drained this cycle;
    // a request seen while reset is high is never accepted.
    assign bus.req_ready = (state_q == ST_EMPTY) | bus.rsp_ready;
    assign accept_s      = bus.req_valid & bus.req_ready & ~reset;

    // Flag register next state and the forwarded flags used for evaluation.
    always_comb begin
        nzcv_d      = nzcv_q;
        eff_flags_s = nzcv_q;
        if (flag_clr) begin
            nzcv_d      = 4'b0000;
            eff_flags_s = 4'b0000;
        end else if (flag_we) begin
            nzcv_d      = {n_in, z_in, c_in, v_in};
            eff_flags_s = {n_in, z_in, c_in, v_in};
        end else begin
            nzcv_d      = nzcv_q;
            eff_flags_s = nzcv_q;
        end
        eval_s = eval_cond(bus.req_cond, eff_flags_s);
    end

    // Response slot state machine and payload capture.
    always_comb begin
        state_d     = state_q;
        rsp_taken_d = rsp_taken_q;
        rsp_err_d   = rsp_err_q;
        rsp_tag_d   = rsp_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (bus.rsp_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept_s) begin
            rsp_taken_d = eval_s[0];
            rsp_err_d   = eval_s[1];
            rsp_tag_d   = bus.req_tag;
        end else begin
            rsp_taken_d = rsp_taken_q;
            rsp_err_d   = rsp_err_q;
            rsp_tag_d   = rsp_tag_q;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_comb begin
        cnt_taken_d = cnt_taken_q;
        cnt_nt_d    = cnt_nt_q;
        if (cnt_clr) begin
            cnt_taken_d = {CNT_W{1'b0}};
            cnt_nt_d    = {CNT_W{1'b0}};
        end else if (accept_s && eval_s[0]) begin
            cnt_taken_d = (cnt_taken_q == CNT_MAX) ? cnt_taken_q : cnt_taken_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (accept_s) begin
            cnt_nt_d = (cnt_nt_q == CNT_MAX) ? cnt_nt_q : cnt_nt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_taken_d = cnt_taken_q;
            cnt_nt_d    = cnt_nt_q;
        end
    end

    // State registers with synchronous reset; a pending response is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            nzcv_q      <= 4'b0000;
            rsp_taken_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tag_q   <= {TAG_W{1'b0}};
            cnt_taken_q <= {CNT_W{1'b0}};
            cnt_nt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            nzcv_q      <= nzcv_d;
            rsp_taken_q <= rsp_taken_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tag_q   <= rsp_tag_d;
            cnt_taken_q <= cnt_taken_d;
            cnt_nt_q    <= cnt_nt_d;
        end
    end

    assign bus.rsp_valid  = (state_q == ST_FULL);
    assign bus.rsp_taken  = rsp_taken_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign nzcv           = nzcv_q;
    assign cnt_taken      = cnt_taken_q;
    assign cnt_not_taken  = cnt_nt_q;
endmodule
